ixc_assign_arb: RTL
===================

# ixc_assign_arb

Round-robin arbiter and sequencer for a shared W-bit assign channel in the IXCOM template library. Up to NREQ requesters each present a W-bit value. The block grants one owner at a time, registers that owner's value onto the shared output L, and bounds each ownership to MAX_HOLD cycles so the channel stays fair. It sits in front of the per-bit assign primitives and drives their R side.

## Interface

Parameters:
- NREQ, 4 — number of requesters; legal range 1..16.
- W, 4 — channel width in bits.
- MAX_HOLD, 4 — maximum consecutive cycles one owner may keep the grant; must be ≥1.

Ports:
- clk — in — 1 — single clock; all state updates on the rising edge.
- rst — in — 1 — synchronous, active-high reset.
- req — in — NREQ — request vector; bit i is requester i.
- data — in — NREQ*W — requester i's value at bits [i*W +: W].
- gnt — out — NREQ — one-hot grant to the current owner; all zeros when idle.
- L — out — W — registered value of the owner's data.
- L_vld — out — 1 — L carries an owner's value this cycle.
- busy — out — 1 — high when the FSM is in OWN.

## Operation

- State machine has two states, IDLE and OWN. Internal registers:
  - ptr: round-robin start index, clog2(NREQ) bits.
  - owner: index of the current owner.
  - hold_cnt: clog2(MAX_HOLD+1) bits.
- Pick function: the first set bit of req, searching from ptr upward and wrapping modulo NREQ.
- IDLE:
  - If req is nonzero: owner <= pick; gnt <= onehot(pick); L <= data[pick]; L_vld <= 1; hold_cnt <= 1; go to OWN.
  - Otherwise stay in IDLE with gnt = 0 and L_vld = 0.
- OWN, continue: if req[owner] = 1 and hold_cnt < MAX_HOLD, then L <= data[owner] and hold_cnt increments. gnt and owner are unchanged.
- OWN, release: triggered when req[owner] = 0 or hold_cnt = MAX_HOLD.
  - ptr <= (owner+1) mod NREQ.
  - Re-arbitrate in the same cycle using the new start index.
  - If a requester is found, grant it with hold_cnt <= 1 and stay in OWN. The previous owner is eligible if it is the only requester; it then gets a fresh hold window.
  - If none is found, go to IDLE with gnt <= 0 and L_vld <= 0.
- In IDLE, L keeps its last value. Consumers qualify L with L_vld.
- Changes to data for non-owners are ignored. The owner's data is sampled every cycle.
- NREQ = 1: degenerates to a pass-through register. The single requester is regranted on each MAX_HOLD expiry.

## Timing

- Reset values: gnt = 0, L = 0, L_vld = 0, busy = 0, ptr = 0, owner = 0, hold_cnt = 0, state = IDLE.
- Grant latency: req rising at edge t gives gnt and L_vld at t+1. L = data[owner] as sampled at edge t.
- Data latency while owning: exactly one cycle, data at t appears on L at t+1.
- Handover has no bubble. The cycle after a release shows the new owner's gnt and data.
- Forced rotation: an owner holding req continuously sees gnt high for exactly MAX_HOLD cycles, then loses it for at least one cycle if any other requester is active.
- MAX_HOLD = 1: the grant rotates every cycle among active requesters.
- If rst is asserted mid-ownership, all registers take reset values at that edge and the interrupted transfer is not resumed. rst has priority over every request.
- Simultaneous req deassert and hold expiry are handled as a single release. ptr advances once.

## Structure

- Package ixc_assign_arb_pkg holds:
  - the state enum (IDLE, OWN);
  - a helper function computing the clog2-sized ptr and hold_cnt widths.
- Sub-module ixc_assign_rr_pick: combinational rotate-priority picker.
  - Inputs: req, start index.
  - Outputs: found, index, onehot.
  - Instantiated once.
- The top level holds the FSM, counters, and the W-bit output register.

## Test plan

- Reset then idle: rst for 2 cycles, req = 0 → gnt = 0, L = 0, L_vld = 0, busy = 0 on every cycle.
- Single requester: req = 0001, data0 = 4'hA for 3 cycles, then drop → gnt = 0001 and L = A from cycle t+1 for 3 cycles. Next cycle gnt = 0 and L_vld = 0, while L still reads A.
- Fairness: req = 1111 held, data i = i, MAX_HOLD = 4 → owners 0, 1, 2, 3 in turn, each exactly 4 cycles, no idle gaps. L shows 0, 1, 2, 3 in 4-cycle runs.
- Early release: owner 1 drops req after 2 cycles while req2 is high → gnt = 0100 on the next cycle and ptr = 2. There is no bubble, and L shows data2 immediately.
- Wrap and lone requester: ptr = 3, only req0 active → owner 0 is granted. With MAX_HOLD = 2 and req0 held, it is regranted every 2 cycles with gnt continuously 0001.
- Reset mid-hold: rst asserted during owner 2, hold_cnt = 3 → next cycle all outputs are 0. After release, with req = 1111, owner 0 is granted first.

Source files
------------

// File: rtl/ixc_assign_arb_pkg.sv
// Shared types and width helpers for the round-robin assign-channel arbiter.
package ixc_assign_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Width of a register able to index n values; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ixc_assign_rr_pick.sv
// Rotate-priority picker: first set request at or above start, wrapping modulo NREQ.
module ixc_assign_rr_pick
   import ixc_assign_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   start,
   output logic            found,
   output logic [IW-1:0]   index,
   output logic [NREQ-1:0] onehot
);

   logic [IW:0]   pos;
   logic [IW-1:0] idx;

   always_comb begin
      found  = 1'b0;
      index  = '0;
      onehot = '0;
      pos    = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, start} + (IW+1)'(k);
         if (pos >= (IW+1)'(NREQ)) begin
            pos = pos - (IW+1)'(NREQ);
         end
         idx = pos[IW-1:0];
         if (!found && req[idx]) begin
            found       = 1'b1;
            index       = idx;
            onehot[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ixc_assign_arb.sv
// Round-robin owner selection for a shared W-bit assign channel, with a bounded
// hold window per owner and a registered copy of the owner's value on L.
module ixc_assign_arb
   import ixc_assign_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int W        = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] data,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      L,
   output logic              L_vld,
   output logic              busy
);

   localparam int IW = idx_width(NREQ);
   localparam int HW = idx_width(MAX_HOLD + 1);

   state_t          state, state_next;
   logic [IW-1:0]   ptr, ptr_next;
   logic [IW-1:0]   owner, owner_next;
   logic [HW-1:0]   hold_cnt, hold_next;
   logic [NREQ-1:0] gnt_next;
   logic [W-1:0]    l_next;
   logic            vld_next;

   logic [W-1:0]    data_arr [NREQ];
   logic            release_own;
   logic [IW-1:0]   rel_start;
   logic [IW-1:0]   start;
   logic            pick_found;
   logic [IW-1:0]   pick_index;
   logic [NREQ-1:0] pick_onehot;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = data[i*W +: W];
      end
   end

   // A release re-arbitrates in the same cycle from the slot after the owner.
   always_comb begin
      release_own = !req[owner] || (hold_cnt == HW'(MAX_HOLD));
      if (owner == IW'(NREQ - 1)) begin
         rel_start = '0;
      end else begin
         rel_start = owner + IW'(1);
      end
      start = (state == OWN) ? rel_start : ptr;
   end

   ixc_assign_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (req),
      .start  (start),
      .found  (pick_found),
      .index  (pick_index),
      .onehot (pick_onehot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      owner_next = owner;
      hold_next  = hold_cnt;
      gnt_next   = gnt;
      l_next     = L;
      vld_next   = L_vld;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_next = OWN;
               owner_next = pick_index;
               gnt_next   = pick_onehot;
               l_next     = data_arr[pick_index];
               vld_next   = 1'b1;
               hold_next  = HW'(1);
            end else begin
               gnt_next = '0;
               vld_next = 1'b0;
            end
         end
         OWN: begin
            if (!release_own) begin
               l_next    = data_arr[owner];
               hold_next = hold_cnt + HW'(1);
            end else begin
               ptr_next = rel_start;
               if (pick_found) begin
                  owner_next = pick_index;
                  gnt_next   = pick_onehot;
                  l_next     = data_arr[pick_index];
                  vld_next   = 1'b1;
                  hold_next  = HW'(1);
               end else begin
                  state_next = IDLE;
                  gnt_next   = '0;
                  vld_next   = 1'b0;
                  hold_next  = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         owner    <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         L        <= '0;
         L_vld    <= 1'b0;
      end else begin
         ptr      <= ptr_next;
         owner    <= owner_next;
         hold_cnt <= hold_next;
         gnt      <= gnt_next;
         L        <= l_next;
         L_vld    <= vld_next;
      end
   end

   always_comb begin
      busy = (state == OWN);
   end

endmodule
